// File: rtl/reservoir_history_reader.sv
// reservoir_history_reader
//
// Read-side engine for the reservoir history RAM.
//
// When a job is accepted, the block reads `length` consecutive words from
// the RAM, starting at `base_addr`. The address wraps from the top of the
// address space back to 0. The words are streamed out on a valid/ready
// interface. The RAM has a 1-cycle read latency, and a 2-entry FIFO absorbs
// both that latency and backpressure from the consumer.
//
// Ports
//   S_AXI_ACLK     clock, rising edge
//   S_AXI_ARESETN  asynchronous active-low reset
//   start          1-cycle pulse that starts a job; ignored while busy
//   abort          synchronous abort of the running job
//   base_addr      first RAM address, sampled when a start is accepted
//   length         number of words to read, sampled when a start is
//                  accepted; 0 is allowed
//   ram_ren        RAM read enable
//   ram_addr       RAM read address
//   ram_dout       RAM read data, valid the cycle after ram_ren
//   m_data         stream data
//   m_valid        stream valid
//   m_last         marks the final word of the job
//   m_ready        stream ready from the consumer
//   busy           high while a job is in progress (FETCH, DRAIN, DONE)
//   done           1-cycle pulse at job completion or abort

module reservoir_history_reader #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  ram_ren,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH:0]   len_r;
    logic [ADDR_WIDTH:0]   len_minus_one;
    logic [ADDR_WIDTH:0]   issued;
    logic [ADDR_WIDTH:0]   delivered;
    logic                  in_flight;
    logic [DATA_WIDTH-1:0] fifo_mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            fifo_count;
    logic [2:0]            credit_used;
    logic                  accept;
    logic                  abort_eff;
    logic                  issue;
    logic                  capture;
    logic                  pop;

    assign accept        = (state == IDLE) && start;
    assign abort_eff     = abort && (state != IDLE);
    assign pop           = m_valid && m_ready;
    assign len_minus_one = len_r - CNT_ONE;

    // An aborted job throws away the word returning from the RAM this cycle.
    assign capture = in_flight && !abort_eff;

    // The credit check counts the FIFO occupancy and the read in flight.
    // A pop in the same cycle frees its slot immediately, which lets a
    // consumer that is always ready get one word per cycle. Issuing only
    // while this sum is below 2 guarantees that a returning word always has
    // a free FIFO entry.
    assign credit_used = {1'b0, fifo_count} + {2'b00, in_flight} - {2'b00, pop};

    assign issue = (state == FETCH) && !abort && (issued != len_r) &&
                   (credit_used < 3'd2);

    assign ram_ren  = issue;
    assign ram_addr = cur_addr;
    assign m_valid  = (fifo_count != 2'd0);
    assign m_data   = fifo_mem[rd_ptr];
    assign m_last   = m_valid && (delivered == len_minus_one);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    // Next-state logic. FETCH moves to DRAIN on the edge that issues the
    // last read. DRAIN waits until the FIFO is empty and no read is in
    // flight. An abort in any active state forces DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (length == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (issue && (issued == len_minus_one)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if ((fifo_count == 2'd0) && !in_flight) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (abort_eff) begin
            state_next = DONE;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Job bookkeeping: the read address, the issued-read and delivered-word
    // counters, and the marker for the single read in flight.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            cur_addr  <= '0;
            len_r     <= '0;
            issued    <= '0;
            delivered <= '0;
            in_flight <= 1'b0;
        end else begin
            in_flight <= issue;
            if (accept) begin
                cur_addr  <= base_addr;
                len_r     <= length;
                issued    <= '0;
                delivered <= '0;
            end else begin
                if (issue) begin
                    cur_addr <= cur_addr + ADDR_ONE;
                    issued   <= issued + CNT_ONE;
                end
                if (pop) begin
                    delivered <= delivered + CNT_ONE;
                end
            end
        end
    end

    // 2-entry output FIFO. An abort empties it so that m_valid drops on the
    // next cycle.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < 2; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else if (abort_eff) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (capture) begin
                fifo_mem[wr_ptr] <= ram_dout;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= fifo_count + {1'b0, capture} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_reservoir_history_reader.sv
// tb_reservoir_history_reader
//
// Directed testbench for reservoir_history_reader.
//
// A behavioural RAM returns its own address as data, so the expected
// addresses and data words below are written out by hand. Each job is run
// cycle by cycle. The bench records the issued addresses, the delivered
// words with their delivery cycles, the m_last pulses, the done pulses and
// the stall stability of the stream, and then compares them against fixed
// expectations.

module tb_reservoir_history_reader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [19:0] base_addr;
    logic [20:0] length;
    logic        ram_ren;
    logic [19:0] ram_addr;
    logic [31:0] ram_dout;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [19:0] got_addr[$];
    logic [31:0] got_data[$];
    int          got_cycle[$];
    int          last_count;
    int          last_index;
    int          done_count;
    int          done_cycle;
    int          first_ren;
    int          stable_err;
    int          valid_after_abort;
    int          abort_cycle;
    int          timed_out;

    reservoir_history_reader #(
        .ADDR_WIDTH(20),
        .DATA_WIDTH(32)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rst_n),
        .start        (start),
        .abort        (abort),
        .base_addr    (base_addr),
        .length       (length),
        .ram_ren      (ram_ren),
        .ram_addr     (ram_addr),
        .ram_dout     (ram_dout),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_last       (m_last),
        .m_ready      (m_ready),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM with 1-cycle read latency: RAM[a] = a.
    always @(posedge clk) begin
        if (ram_ren) begin
            ram_dout <= {12'h000, ram_addr};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Runs one job and records what happened. Cycle 0 is the cycle in which
    // start is driven. A second start pulse can be injected at spur_cycle
    // (if >= 0), and an abort is raised once abort_after words have been
    // delivered (if >= 0).
    task automatic applyStimulus(input logic [19:0] base, input logic [20:0] len,
                                 input int ready_pct, input int abort_after,
                                 input int spur_cycle, input int budget);
        logic [31:0] prev_data;
        logic        prev_stall;
        got_addr.delete();
        got_data.delete();
        got_cycle.delete();
        last_count        = 0;
        last_index        = -1;
        done_count        = 0;
        done_cycle        = -1;
        first_ren         = -1;
        stable_err        = 0;
        valid_after_abort = 0;
        abort_cycle       = -1;
        timed_out         = 1;
        prev_stall        = 1'b0;
        prev_data         = '0;
        start     = 1'b1;
        base_addr = base;
        length    = len;
        tick();
        start = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            if (c == spur_cycle) begin
                start     = 1'b1;
                base_addr = 20'h0_0900;
                length    = 21'd3;
            end else begin
                start = 1'b0;
            end
            m_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(99) < ready_pct);
            abort   = (abort_after >= 0) && (got_data.size() == abort_after) &&
                      (abort_cycle < 0);
            if (abort) begin
                abort_cycle = c;
                m_ready     = 1'b0;
            end
            #1;
            if (!busy && done_count > 0) begin
                timed_out = 0;
                break;
            end
            if (ram_ren) begin
                got_addr.push_back(ram_addr);
                if (first_ren < 0) first_ren = c;
            end
            if (prev_stall && (!m_valid || m_data !== prev_data)) stable_err++;
            if (abort_cycle >= 0 && c == abort_cycle + 1 && m_valid) valid_after_abort++;
            if (m_valid && m_ready) begin
                got_data.push_back(m_data);
                got_cycle.push_back(c);
                if (m_last) begin
                    last_count++;
                    last_index = got_data.size() - 1;
                end
            end
            prev_stall = m_valid && !m_ready && !abort;
            prev_data  = m_data;
            if (done) begin
                done_count++;
                done_cycle = c;
            end
            tick();
        end
        start   = 1'b0;
        abort   = 1'b0;
        m_ready = 1'b1;
    endtask

    function automatic logic [31:0] dataAt(input int i);
        return (i < got_data.size()) ? got_data[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] addrAt(input int i);
        return (i < got_addr.size()) ? {12'h000, got_addr[i]} : 32'hDEAD_BEEF;
    endfunction

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        base_addr = '0;
        length    = '0;
        m_ready   = 1'b1;
        #3;
        checkOutput("rst_busy",    32'(busy),    32'd0);
        checkOutput("rst_done",    32'(done),    32'd0);
        checkOutput("rst_ram_ren", 32'(ram_ren), 32'd0);
        checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("rst_m_last",  32'(m_last),  32'd0);
        checkOutput("rst_ram_addr", {12'h000, ram_addr}, 32'd0);
        checkOutput("rst_m_data",  m_data,       32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] job 1: base 0x10, length 4, ready always");
        applyStimulus(20'h0_0010, 21'd4, 100, -1, -1, 100);
        checkOutput("j1_timeout", 32'(timed_out), 32'd0);
        checkOutput("j1_first_ren", 32'(first_ren), 32'd1);
        checkOutput("j1_addr_cnt", 32'(got_addr.size()), 32'd4);
        for (int i = 0; i < 4; i++) checkOutput("j1_addr", addrAt(i), 32'h10 + 32'(i));
        checkOutput("j1_data_cnt", 32'(got_data.size()), 32'd4);
        for (int i = 0; i < 4; i++) checkOutput("j1_data", dataAt(i), 32'h10 + 32'(i));
        if (got_cycle.size() == 4)
            checkOutput("j1_back_to_back", 32'(got_cycle[3] - got_cycle[0]), 32'd3);
        checkOutput("j1_last_cnt", 32'(last_count), 32'd1);
        checkOutput("j1_last_idx", 32'(last_index), 32'd3);
        checkOutput("j1_done_cnt", 32'(done_count), 32'd1);

        $display("[TB] job 2: length 0, extra start during DONE");
        applyStimulus(20'h0_0020, 21'd0, 100, -1, 1, 50);
        checkOutput("j2_timeout", 32'(timed_out), 32'd0);
        checkOutput("j2_addr_cnt", 32'(got_addr.size()), 32'd0);
        checkOutput("j2_data_cnt", 32'(got_data.size()), 32'd0);
        checkOutput("j2_done_cycle", 32'(done_cycle), 32'd1);
        checkOutput("j2_done_cnt", 32'(done_count), 32'd1);

        $display("[TB] job 3: wrap at top of address space");
        applyStimulus(20'hF_FFFE, 21'd4, 100, -1, -1, 100);
        checkOutput("j3_timeout", 32'(timed_out), 32'd0);
        checkOutput("j3_addr0", addrAt(0), 32'h000F_FFFE);
        checkOutput("j3_addr1", addrAt(1), 32'h000F_FFFF);
        checkOutput("j3_addr2", addrAt(2), 32'h0000_0000);
        checkOutput("j3_addr3", addrAt(3), 32'h0000_0001);
        checkOutput("j3_data3", dataAt(3), 32'h0000_0001);
        checkOutput("j3_last_idx", 32'(last_index), 32'd3);

        $display("[TB] job 4: length 8, ready about half the time");
        applyStimulus(20'h0_0300, 21'd8, 50, -1, 3, 300);
        checkOutput("j4_timeout", 32'(timed_out), 32'd0);
        checkOutput("j4_addr_cnt", 32'(got_addr.size()), 32'd8);
        checkOutput("j4_data_cnt", 32'(got_data.size()), 32'd8);
        for (int i = 0; i < 8; i++) checkOutput("j4_data", dataAt(i), 32'h300 + 32'(i));
        checkOutput("j4_stable", 32'(stable_err), 32'd0);
        checkOutput("j4_last_cnt", 32'(last_count), 32'd1);
        checkOutput("j4_last_idx", 32'(last_index), 32'd7);
        checkOutput("j4_done_cnt", 32'(done_count), 32'd1);

        $display("[TB] job 5: length 16, abort after 5 words");
        applyStimulus(20'h0_0040, 21'd16, 100, 5, -1, 200);
        checkOutput("j5_timeout", 32'(timed_out), 32'd0);
        checkOutput("j5_data_cnt", 32'(got_data.size()), 32'd5);
        checkOutput("j5_data4", dataAt(4), 32'h44);
        checkOutput("j5_valid_after_abort", 32'(valid_after_abort), 32'd0);
        checkOutput("j5_last_cnt", 32'(last_count), 32'd0);
        checkOutput("j5_done_cnt", 32'(done_count), 32'd1);
        checkOutput("j5_done_cycle", 32'(done_cycle), 32'(abort_cycle + 1));

        $display("[TB] job 5b: new job after abort");
        applyStimulus(20'h0_0500, 21'd3, 100, -1, -1, 100);
        checkOutput("j5b_timeout", 32'(timed_out), 32'd0);
        checkOutput("j5b_data_cnt", 32'(got_data.size()), 32'd3);
        for (int i = 0; i < 3; i++) checkOutput("j5b_data", dataAt(i), 32'h500 + 32'(i));
        checkOutput("j5b_last_idx", 32'(last_index), 32'd2);

        $display("[TB] job 6: reset asserted mid-job");
        start     = 1'b1;
        base_addr = 20'h0_0A00;
        length    = 21'd10;
        m_ready   = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("j6_busy",     32'(busy),    32'd0);
        checkOutput("j6_done",     32'(done),    32'd0);
        checkOutput("j6_ram_ren",  32'(ram_ren), 32'd0);
        checkOutput("j6_m_valid",  32'(m_valid), 32'd0);
        checkOutput("j6_m_last",   32'(m_last),  32'd0);
        checkOutput("j6_ram_addr", {12'h000, ram_addr}, 32'd0);
        checkOutput("j6_m_data",   m_data,       32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("j6_post_busy", 32'(busy), 32'd0);
        checkOutput("j6_post_done", 32'(done), 32'd0);
        applyStimulus(20'h0_0B00, 21'd2, 100, -1, -1, 100);
        checkOutput("j6b_timeout", 32'(timed_out), 32'd0);
        checkOutput("j6b_data_cnt", 32'(got_data.size()), 32'd2);
        checkOutput("j6b_data0", dataAt(0), 32'hB00);
        checkOutput("j6b_data1", dataAt(1), 32'hB01);
        checkOutput("j6b_done_cnt", 32'(done_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
